path_launch_capture: RTL and testbench

//  Launch/capture controller for the inverter-chain delay paths (singlepath_*_N).
//  - Drives the path input from a flop and samples the path output exactly one clock later.
//  - Compares each sample with the expected value, repeats TRIALS times, reports the error count.
//  - A nonzero count means the path delay exceeded the clock period at this clock and voltage.

---
 rtl/path_launch_capture.sv | 146 ++++++++++++++
 tb/tb_path_launch_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/path_launch_capture.sv
// path_launch_capture: launch/capture controller for inverter-chain delay paths.
// Each trial toggles path_launch from a flop, samples path_sample one clock later,
// compares the sample with the expected polarity and accumulates mismatches.
// Repeats TRIALS times with GAP_CYCLES idle cycles between trials, then pulses done.
// A nonzero err_count means the path delay exceeded the clock period.
// Optional feature: define PATH_FIRST_FAIL_EN to add first_fail_valid / first_fail_idx,
// which report the 0-based index of the first mismatching trial of a run.
module path_launch_capture #(
  parameter int TRIALS      = 256,
  parameter int CNT_W       = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int PATH_INVERT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             path_launch,
  input  logic             path_sample,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] trial_count
`ifdef PATH_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
`endif
);

  // Odd inversion parity through the chain flips the expected sample.
  localparam logic EXP_INV = (PATH_INVERT != 0);

  // Gap counter only needs to reach GAP_CYCLES-1; keep at least one bit.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] TRIALS_C  = CNT_W'(TRIALS);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_CYCLES - 1);

  // Run sequencer states.
  localparam logic [2:0] stIdle    = 3'd0;
  localparam logic [2:0] stCapture = 3'd1;
  localparam logic [2:0] stCheck   = 3'd2;
  localparam logic [2:0] stGap     = 3'd3;
  localparam logic [2:0] stDone    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic             sampleQ;
  logic [GAP_W-1:0] gapCnt;
  logic [CNT_W-1:0] trialNext;

  logic startRun;
  logic inCheck;
  logic isMiss;
  logic lastTrial;
  logic gapLast;
  logic errSat;
  logic launchToggle;

  // start is only honoured while idle; a held start re-launches after done.
  assign startRun  = (state == stIdle) && start;
  assign inCheck   = (state == stCheck);
  // The comparison always uses the captured sample, never the live path output.
  // path_launch is still stable during CHECK: it only toggles at a run start or a gap end.
  assign isMiss    = (sampleQ != (path_launch ^ EXP_INV));
  assign trialNext = trial_count + CNT_W'(1);
  assign lastTrial = (trialNext == TRIALS_C);
  assign gapLast   = (gapCnt == GAP_LAST_C);
  assign errSat    = &err_count;

  // Launch edges: the first trial launches from idle, later trials at the end of a gap.
  assign launchToggle = startRun || ((state == stGap) && gapLast);

  // done lasts exactly the single DONE cycle; busy drops in that same cycle.
  assign busy = (state == stCapture) || (state == stCheck) || (state == stGap);
  assign done = (state == stDone);

  // Next-state decode for the trial sequencer.
  always_comb begin
    nextState = state;
    case (state)
      stIdle:    if (start) nextState = stCapture;
      stCapture: nextState = stCheck;
      stCheck:   nextState = lastTrial ? stDone : stGap;
      stGap:     if (gapLast) nextState = stCapture;
      stDone:    nextState = stIdle;
      default:   nextState = stIdle;
    endcase
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= stIdle;
    else        state <= nextState;
  end

  // Launch flop; polarity alternates every trial so both edges get measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            path_launch <= 1'b0;
    else if (launchToggle) path_launch <= ~path_launch;
  end

  // Capture flop: first and only flop on the raw path output, one clock after launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sampleQ <= 1'b0;
    else if (state == stCapture) sampleQ <= path_sample;
  end

  // Gap counter: counts GAP_CYCLES cycles of settling time between trials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gapCnt <= '0;
    else if (state == stGap) gapCnt <= gapLast ? '0 : gapCnt + GAP_W'(1);
    else                     gapCnt <= '0;
  end

  // Error counter: cleared at run start, saturates at all-ones, holds after the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_count <= '0;
    else if (startRun)                   err_count <= '0;
    else if (inCheck && isMiss && !errSat) err_count <= err_count + CNT_W'(1);
  end

  // Trial counter: advances once per CHECK, holds after the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trial_count <= '0;
    else if (startRun) trial_count <= '0;
    else if (inCheck)  trial_count <= trialNext;
  end

`ifdef PATH_FIRST_FAIL_EN
  // First-failure latch: records the index of the first mismatching trial of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (startRun) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (inCheck && isMiss && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= trial_count;
    end
  end
`endif

endmodule

// File: tb/tb_path_launch_capture.sv
// Directed bench for path_launch_capture with behavioural delay-path models.
// Unit 0: TRIALS=8, non-inverting DUT. Unit 1: TRIALS=8, PATH_INVERT=1. Unit 2: TRIALS=1.
module tb_path_launch_capture;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] startV = '0;
  logic [2:0] invV = '0;
  wire  [2:0] launchV;
  wire  [2:0] sampleV;
  wire  [2:0] busyV;
  wire  [2:0] doneV;
  wire  [CW-1:0] errV [3];
  wire  [CW-1:0] trialV [3];
`ifdef PATH_FIRST_FAIL_EN
  wire  [2:0] ffvV;
  wire  [CW-1:0] ffiV [3];
`endif

  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  int tog0 = 0, tog1 = 0, tog2 = 0;
  int dly = 2;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  assign sampleV = {s2, s1, s0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural paths: buffer or inverter with transport delay dly (clock period 10).
  always @(launchV[0] or invV[0]) s0 <= #(dly) (launchV[0] ^ invV[0]);
  always @(launchV[1] or invV[1]) s1 <= #(dly) (launchV[1] ^ invV[1]);
  always @(launchV[2] or invV[2]) s2 <= #(dly) (launchV[2] ^ invV[2]);
  always @(launchV[0]) tog0++;
  always @(launchV[1]) tog1++;
  always @(launchV[2]) tog2++;

  path_launch_capture #(.TRIALS(8), .CNT_W(CW), .GAP_CYCLES(4), .PATH_INVERT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .path_launch(launchV[0]),
    .path_sample(sampleV[0]), .busy(busyV[0]), .done(doneV[0]),
    .err_count(errV[0]), .trial_count(trialV[0])
`ifdef PATH_FIRST_FAIL_EN
    , .first_fail_valid(ffvV[0]), .first_fail_idx(ffiV[0])
`endif
  );

  path_launch_capture #(.TRIALS(8), .CNT_W(CW), .GAP_CYCLES(4), .PATH_INVERT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .path_launch(launchV[1]),
    .path_sample(sampleV[1]), .busy(busyV[1]), .done(doneV[1]),
    .err_count(errV[1]), .trial_count(trialV[1])
`ifdef PATH_FIRST_FAIL_EN
    , .first_fail_valid(ffvV[1]), .first_fail_idx(ffiV[1])
`endif
  );

  path_launch_capture #(.TRIALS(1), .CNT_W(CW), .GAP_CYCLES(4), .PATH_INVERT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .path_launch(launchV[2]),
    .path_sample(sampleV[2]), .busy(busyV[2]), .done(doneV[2]),
    .err_count(errV[2]), .trial_count(trialV[2])
`ifdef PATH_FIRST_FAIL_EN
    , .first_fail_valid(ffvV[2]), .first_fail_idx(ffiV[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int togOf(input int u);
    case (u)
      0:       return tog0;
      1:       return tog1;
      default: return tog2;
    endcase
  endfunction

  // One complete run on unit u; optional spurious start pulses while busy.
  task automatic runOnce(input int u, input string tag, input int expDoneAt, input int expErr,
                         input int expTrials, input int expTog, input logic expLaunch,
                         input bit spurious);
    int t0, startCyc, doneAt;
    @(negedge clk);
    startV[u] = 1'b1;
    t0 = togOf(u);
    @(posedge clk); #1;
    startCyc = cyc;
    startV[u] = 1'b0;
    check({tag, ".busyRise"}, busyV[u], 1);
    check({tag, ".trialClr"}, trialV[u], 0);
    doneAt = -1;
    for (int i = 0; i < 400 && doneAt < 0; i++) begin
      startV[u] = spurious && (i == 5 || i == 12 || i == 20);
      @(posedge clk); #1;
      if (doneV[u]) doneAt = cyc - startCyc;
    end
    startV[u] = 1'b0;
    check({tag, ".doneAt"}, doneAt, expDoneAt);
    check({tag, ".busyFall"}, busyV[u], 0);
    check({tag, ".err"}, errV[u], expErr);
    check({tag, ".trials"}, trialV[u], expTrials);
    check({tag, ".toggles"}, togOf(u) - t0, expTog);
    check({tag, ".launch"}, launchV[u], expLaunch);
`ifdef PATH_FIRST_FAIL_EN
    check({tag, ".ffv"}, ffvV[u], (expErr != 0));
    check({tag, ".ffi"}, ffiV[u], 0);
`endif
    @(posedge clk); #1;
    check({tag, ".donePulse"}, doneV[u], 0);
    check({tag, ".errHold"}, errV[u], expErr);
  endtask

  initial begin
    int startCyc, doneAt, t0;

    // Reset state
    #3;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst%0d.launch", u), launchV[u], 0);
      check($sformatf("rst%0d.busy", u), busyV[u], 0);
      check($sformatf("rst%0d.done", u), doneV[u], 0);
      check($sformatf("rst%0d.err", u), errV[u], 0);
      check($sformatf("rst%0d.trial", u), trialV[u], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: fast path, all trials pass; done 44 edges after start
    dly = 2;
    runOnce(0, "t1", 44, 0, 8, 8, 1'b0, 1'b0);

    // T2: slow path, every trial samples the stale value
    dly = 15;
    runOnce(0, "t2", 44, 8, 8, 8, 1'b0, 1'b0);
    dly = 2;
    repeat (3) @(posedge clk);

`ifdef PATH_FIRST_FAIL_EN
    // T6: trials 0-2 fast, slow from trial 3 onward
    @(negedge clk);
    startV[0] = 1'b1;
    @(posedge clk); #1;
    startCyc = cyc;
    startV[0] = 1'b0;
    check("t6.ffvClear", ffvV[0], 0);
    doneAt = -1;
    for (int i = 0; i < 400 && doneAt < 0; i++) begin
      @(posedge clk); #1;
      if (cyc - startCyc == 15) dly = 15;
      if (doneV[0]) doneAt = cyc - startCyc;
    end
    check("t6.doneAt", doneAt, 44);
    check("t6.ffv", ffvV[0], 1);
    check("t6.ffi", ffiV[0], 3);
    check("t6.err", errV[0], 5);
    dly = 2;
    repeat (3) @(posedge clk);
`endif

    // T3: inverting chain matched by PATH_INVERT=1, then mismatched on a buffer-parity DUT
    invV[1] = 1'b1;
    runOnce(1, "t3inv", 44, 0, 8, 8, 1'b0, 1'b0);
    invV[0] = 1'b1;
    runOnce(0, "t3par", 44, 8, 8, 8, 1'b0, 1'b0);
    invV[0] = 1'b0;
    repeat (2) @(posedge clk);

    // T4: start pulses while busy are ignored
    runOnce(0, "t4", 44, 0, 8, 8, 1'b0, 1'b1);
    t0 = togOf(0);
    repeat (8) @(posedge clk);
    #1;
    check("t4.noRerun", busyV[0], 0);
    check("t4.noToggle", togOf(0) - t0, 0);

    // TRIALS=1: no gap, done two edges after start
    runOnce(2, "one", 2, 0, 1, 1, 1'b1, 1'b0);

    // start held high across done restarts right after the idle cycle
    @(negedge clk);
    startV[2] = 1'b1;
    @(posedge clk); #1;
    startCyc = cyc;
    doneAt = -1;
    for (int i = 0; i < 50 && doneAt < 0; i++) begin
      @(posedge clk); #1;
      if (doneV[2]) doneAt = cyc - startCyc;
    end
    check("hold.doneAt", doneAt, 2);
    @(posedge clk); #1;
    check("hold.idleGap", busyV[2], 0);
    @(posedge clk); #1;
    check("hold.restart", busyV[2], 1);
    check("hold.trialClr", trialV[2], 0);
    startV[2] = 1'b0;
    doneAt = -1;
    for (int i = 0; i < 50 && doneAt < 0; i++) begin
      @(posedge clk); #1;
      if (doneV[2]) doneAt = i;
    end
    check("hold.run2Trials", trialV[2], 1);
    check("hold.run2Err", errV[2], 0);

    // T5: asynchronous reset mid-run aborts everything
    dly = 15;
    @(negedge clk);
    startV[0] = 1'b1;
    @(posedge clk); #1;
    startV[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t5.preErr", errV[0], 4);
    check("t5.preTrial", trialV[0], 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.launch", launchV[0], 0);
    check("t5.busy", busyV[0], 0);
    check("t5.done", doneV[0], 0);
    check("t5.err", errV[0], 0);
    check("t5.trial", trialV[0], 0);
    dly = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    runOnce(0, "t5rerun", 44, 0, 8, 8, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "bench time limit reached");
  end

endmodule
